// File: rtl/mul8s_acc_stage.sv
// ============================================================================
// Module   : mul8s_acc_stage
// Brief    : Frame accumulator for signed 16-bit multiplier products, with a
//            valid/ready result port, sticky overflow and truncation flags.
//            Optional macro MUL8S_ACC_SAT_EN selects saturating accumulation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul8s_acc_stage #(
   parameter int ACC_W   = 24,
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf,
   output logic             out_trunc
);

   localparam logic [0:0]       c_ST_ACCUM = 1'b0;
   localparam logic [0:0]       c_ST_HOLD  = 1'b1;
   localparam logic [CNT_W-1:0] c_MAX_CNT  = CNT_W'(MAX_LEN);
`ifdef MUL8S_ACC_SAT_EN
   localparam logic [ACC_W-1:0] c_POS_SAT  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_NEG_SAT  = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   logic [0:0]       state_q,     state_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             ovf_q,       ovf_d;
   logic [ACC_W-1:0] out_acc_q,   out_acc_d;
   logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
   logic             out_ovf_q,   out_ovf_d;
   logic             out_trunc_q, out_trunc_d;

   logic [ACC_W-1:0] w_prod_ext;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_accept;
   logic             w_ovf_now;
   logic             w_ovf_next;
   logic             w_close;

   generate
      if (ACC_W > 16) begin : g_ext_wide
         assign w_prod_ext = {{(ACC_W-16){in_prod[15]}}, in_prod};
      end else begin : g_ext_exact
         assign w_prod_ext = in_prod;
      end
   endgenerate

   always_comb begin
      w_accept   = in_valid & (state_q == c_ST_ACCUM);
      w_sum      = acc_q + w_prod_ext;
      // Same-sign operands producing a result of the other sign
      w_ovf_now  = (acc_q[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != acc_q[ACC_W-1]);
      w_acc_next = w_sum;
`ifdef MUL8S_ACC_SAT_EN
      if (w_ovf_now) begin
         w_acc_next = acc_q[ACC_W-1] ? c_NEG_SAT : c_POS_SAT;
      end
`endif
      w_cnt_next = cnt_q + CNT_W'(1);
      w_ovf_next = ovf_q | w_ovf_now;
      w_close    = w_accept & (in_last | (w_cnt_next == c_MAX_CNT));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_acc_d   = out_acc_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;
      out_trunc_d = out_trunc_q;

      if (state_q == c_ST_ACCUM) begin
         if (w_close) begin
            out_acc_d   = w_acc_next;
            out_cnt_d   = w_cnt_next;
            out_ovf_d   = w_ovf_next;
            out_trunc_d = ~in_last;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = c_ST_HOLD;
         end else if (w_accept) begin
            acc_d = w_acc_next;
            cnt_d = w_cnt_next;
            ovf_d = w_ovf_next;
         end
      end else begin
         if (out_ready) begin
            state_d = c_ST_ACCUM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_acc_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_trunc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_acc_q   <= out_acc_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
         out_trunc_q <= out_trunc_d;
      end
   end

   assign in_ready  = (state_q == c_ST_ACCUM);
   assign out_valid = (state_q == c_ST_HOLD);
   assign out_acc   = out_acc_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;
   assign out_trunc = out_trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_mul8s_acc_stage.sv
// ============================================================================
// Module   : tb_mul8s_acc_stage
// Brief    : Directed and random frames for mul8s_acc_stage compared against
//            an integer-arithmetic frame model (honours MUL8S_ACC_SAT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul8s_acc_stage;

   localparam int ACC_W   = 16;
   localparam int MAX_LEN = 4;
   localparam int CNT_W   = 3;
   localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint MINV = -(longint'(1) << (ACC_W-1));
   localparam longint SPAN = longint'(1) << ACC_W;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;
   logic             out_trunc;

   mul8s_acc_stage #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_cnt(out_cnt), .out_ovf(out_ovf), .out_trunc(out_trunc)
   );

   typedef struct {
      longint acc;
      int     cnt;
      bit     ovf;
      bit     trunc;
   } res_t;

   res_t   exp_q[$];
   longint m_acc;
   int     m_cnt;
   bit     m_ovf;
   int     n_checks;
   int     n_errors;
   int     rdy_mode;   // 0: always ready, 1: random, 2: stalled

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame model in plain signed arithmetic
   function automatic void model_beat(input logic [15:0] p, input logic last);
      longint s;
      res_t   r;
      s = m_acc + longint'($signed(p));
      if (s > MAXV || s < MINV) begin
         m_ovf = 1'b1;
`ifdef MUL8S_ACC_SAT_EN
         s = (s > MAXV) ? MAXV : MINV;
`else
         s = (s > MAXV) ? s - SPAN : s + SPAN;
`endif
      end
      m_acc = s;
      m_cnt++;
      if (last || m_cnt == MAX_LEN) begin
         r.acc   = m_acc;
         r.cnt   = m_cnt;
         r.ovf   = m_ovf;
         r.trunc = !last;
         exp_q.push_back(r);
         m_acc = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
         if (out_valid && exp_q.size() != 0) begin
            check_eq("res_acc", 32'(out_acc), 32'(exp_q[0].acc[ACC_W-1:0]));
            check_eq("res_cnt", 32'(out_cnt), 32'(exp_q[0].cnt));
            check_eq("res_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0].ovf});
            check_eq("res_trunc", {31'd0, out_trunc}, {31'd0, exp_q[0].trunc});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      step();
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_acc", 32'(out_acc), 32'd0);
      check_eq("rst_out_cnt", 32'(out_cnt), 32'd0);
      check_eq("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      check_eq("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
      rst = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] p, input logic last);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      for (int k = 0; k < 200 && !done; k++) begin
         if (in_ready) done = 1'b1;
         step();
      end
      if (done) model_beat(p, last);
      else check_eq("beat_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) step();
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
      rdy_mode = 0; n_checks = 0; n_errors = 0;
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      repeat (2) step();
      do_reset();

      send_beat(16'h0100, 1'b0);
      send_beat(16'h0100, 1'b0);
      send_beat(16'h0100, 1'b1);
      wait_idle();
      check_eq("basic_acc", 32'(out_acc), 32'h0300);
      check_eq("basic_cnt", 32'(out_cnt), 32'd3);
      check_eq("basic_ovf", {31'd0, out_ovf}, 32'd0);
      check_eq("basic_trunc", {31'd0, out_trunc}, 32'd0);

      send_beat(16'hFF00, 1'b0);
      send_beat(16'h0064, 1'b1);
      wait_idle();
      check_eq("mix_acc", 32'(out_acc), 32'hFF64);
      check_eq("mix_cnt", 32'(out_cnt), 32'd2);

      rdy_mode = 2;
      send_beat(16'h1234, 1'b1);
      repeat (5) step();
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_acc", 32'(out_acc), 32'h1234);
      rdy_mode = 0;
      wait_idle();
      check_eq("bp_release", {31'd0, in_ready}, 32'd1);

      send_beat(16'h7FFF, 1'b0);
      send_beat(16'h0001, 1'b1);
      wait_idle();
`ifdef MUL8S_ACC_SAT_EN
      check_eq("ovf_pos_acc", 32'(out_acc), 32'h7FFF);
`else
      check_eq("ovf_pos_acc", 32'(out_acc), 32'h8000);
`endif
      check_eq("ovf_pos_flag", {31'd0, out_ovf}, 32'd1);
      send_beat(16'h8000, 1'b0);
      send_beat(16'hFFFF, 1'b1);
      wait_idle();
`ifdef MUL8S_ACC_SAT_EN
      check_eq("ovf_neg_acc", 32'(out_acc), 32'h8000);
`else
      check_eq("ovf_neg_acc", 32'(out_acc), 32'h7FFF);
`endif
      check_eq("ovf_neg_flag", {31'd0, out_ovf}, 32'd1);

      for (int i = 0; i < 4; i++) send_beat(16'h0002, 1'b0);
      check_eq("trunc_acc", 32'(out_acc), 32'd8);
      check_eq("trunc_cnt", 32'(out_cnt), 32'd4);
      check_eq("trunc_flag", {31'd0, out_trunc}, 32'd1);
      send_beat(16'h0002, 1'b0);
      send_beat(16'h0003, 1'b1);
      wait_idle();
      check_eq("after_trunc_acc", 32'(out_acc), 32'd5);
      check_eq("after_trunc_cnt", 32'(out_cnt), 32'd2);

      send_beat(16'h0010, 1'b0);
      send_beat(16'h0010, 1'b0);
      do_reset();
      send_beat(16'h0005, 1'b1);
      wait_idle();
      check_eq("rstmid_acc", 32'(out_acc), 32'd5);
      check_eq("rstmid_cnt", 32'(out_cnt), 32'd1);
      check_eq("rstmid_ovf", {31'd0, out_ovf}, 32'd0);

      rdy_mode = 2;
      send_beat(16'h0042, 1'b1);
      step();
      do_reset();
      rdy_mode = 0;

      rdy_mode = 1;
      for (int f = 0; f < 60; f++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            logic [15:0] p;
            p = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            send_beat(p, b == len - 1);
            if ($urandom_range(0, 3) == 0) step();
         end
      end
      rdy_mode = 0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
